// File: rtl/ap3_fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// ap3_fifo_ctrl_pkg : shared constants, flag layout and flag helper | rev 1.0
// ============================================================================
package ap3_fifo_ctrl_pkg;

  localparam int unsigned DEF_DATA_W = 32;   // x32 RAM port (RMODE/WMODE = 2'b10)
  localparam int unsigned DEF_ADDR_W = 9;

  localparam int FLG_EMPTY  = 0;
  localparam int FLG_AEMPTY = 1;
  localparam int FLG_AFULL  = 2;
  localparam int FLG_FULL   = 3;

  localparam logic [3:0] FLAGS_RESET = 4'b0011;

  typedef logic [3:0] flags_t;

  function automatic flags_t make_flags(input int unsigned level,
                                        input int unsigned mem_cnt,
                                        input int unsigned depth,
                                        input int unsigned ae_level,
                                        input int unsigned af_level);
    flags_t f;
    f             = '0;
    f[FLG_EMPTY]  = (level == 0);
    f[FLG_AEMPTY] = (level <= ae_level);
    f[FLG_AFULL]  = (level >= af_level);
    f[FLG_FULL]   = (mem_cnt == depth);
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ap3_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// ap3_fifo_ctrl_if : valid/ready data stream with master/slave views | rev 1.0
// ============================================================================
interface ap3_fifo_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);
endinterface
`default_nettype wire

// File: rtl/ap3_fifo_obuf.sv
`default_nettype none
// ============================================================================
// ap3_fifo_obuf : 2-entry first-word-fall-through output buffer | rev 1.0
// ============================================================================
module ap3_fifo_obuf #(
  parameter int unsigned DATA_W = 32
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              flush,
  input  wire logic              wr_en,
  input  wire logic [DATA_W-1:0] wr_data,
  input  wire logic              m_ready,
  output logic      [DATA_W-1:0] m_data,
  output logic                   m_valid,
  output logic      [1:0]        count
);

  logic [DATA_W-1:0] ent0;   // head entry
  logic [DATA_W-1:0] ent1;
  logic              pop;

  assign m_valid = (count != 2'd0);
  assign m_data  = ent0;
  assign pop     = m_valid & m_ready;

  // The upstream credit rule guarantees wr_en never arrives with count==2 and no pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0  <= '0;
      ent1  <= '0;
      count <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({wr_en, pop})
        2'b10: begin
          if (count == 2'd0) ent0 <= wr_data;
          else               ent1 <= wr_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd2) begin
            ent0 <= ent1;
            ent1 <= wr_data;
          end else begin
            ent0 <= wr_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ap3_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// ap3_fifo_ctrl : FWFT FIFO controller around one AP3 RAM block | rev 1.0
// ============================================================================
module ap3_fifo_ctrl
  import ap3_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned AE_LEVEL = 4,
  parameter int unsigned AF_LEVEL = 508
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              flush,
  ap3_fifo_ctrl_if.slave         s_stream,
  ap3_fifo_ctrl_if.master        m_stream,
  output logic      [ADDR_W-1:0] ram_waddr,
  output logic      [DATA_W-1:0] ram_wdata,
  output logic                   ram_wen,
  output logic      [ADDR_W-1:0] ram_raddr,
  output logic                   ram_ren,
  input  wire logic [DATA_W-1:0] ram_rdata,
  output logic      [ADDR_W+1:0] level,
  output flags_t                 flags
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   mem_cnt;
  logic [ADDR_W:0]   mem_cnt_nxt;
  logic [ADDR_W+1:0] level_nxt;
  logic              inflight;
  logic              armed;       // holds ready low until the first edge out of reset
  logic              push;
  logic              pop;
  logic              capture;
  logic [2:0]        credit;
  logic [1:0]        obuf_cnt;
  logic              obuf_valid;
  logic [DATA_W-1:0] obuf_data;

  assign s_stream.ready = armed & ~flags[FLG_FULL] & ~flush;
  assign push           = s_stream.valid & s_stream.ready;
  assign pop            = obuf_valid & m_stream.ready;
  assign capture        = inflight & ~flush;

  // A read may only issue if the buffer will have room when its data lands.
  assign credit  = 3'(obuf_cnt) + 3'(inflight) - 3'(pop);
  assign ram_ren = (mem_cnt != '0) & ~flush & (credit <= 3'd1);

  assign ram_waddr = wr_ptr;
  assign ram_wdata = s_stream.data;
  assign ram_wen   = push;
  assign ram_raddr = rd_ptr;

  // Words only enter at push and leave at pop; RAM->buffer moves keep the total.
  assign mem_cnt_nxt = flush ? '0 : mem_cnt + (ADDR_W+1)'(push) - (ADDR_W+1)'(ram_ren);
  assign level_nxt   = flush ? '0 : level + (ADDR_W+2)'(push) - (ADDR_W+2)'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
      armed    <= 1'b0;
      level    <= '0;
      flags    <= FLAGS_RESET;
    end else begin
      armed <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)    wr_ptr <= wr_ptr + ADDR_W'(1);
        if (ram_ren) rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      mem_cnt  <= mem_cnt_nxt;
      inflight <= ram_ren;
      level    <= level_nxt;
      flags    <= make_flags(32'(level_nxt), 32'(mem_cnt_nxt), DEPTH, AE_LEVEL, AF_LEVEL);
    end
  end

  ap3_fifo_obuf #(
    .DATA_W (DATA_W)
  ) u_obuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (capture),
    .wr_data (ram_rdata),
    .m_ready (m_stream.ready),
    .m_data  (obuf_data),
    .m_valid (obuf_valid),
    .count   (obuf_cnt)
  );

  assign m_stream.data  = obuf_data;
  assign m_stream.valid = obuf_valid;

endmodule
`default_nettype wire

// File: tb/tb_ap3_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ap3_fifo_ctrl : self-checking bench with queue reference model | rev 1.0
// ============================================================================
module tb_ap3_fifo_ctrl;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;
  localparam int AE     = 4;
  localparam int AF     = 508;

  typedef struct {
    logic [31:0] d;
    int          t;
  } word_t;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] ram_waddr;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_wen;
  logic              ram_ren;
  logic [ADDR_W+1:0] level;
  logic [3:0]        flags;
  logic [DATA_W-1:0] ram [DEPTH];

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  bit    armed    = 1'b0;
  word_t q[$];

  ap3_fifo_ctrl_if #(.DATA_W(DATA_W)) s_bus ();
  ap3_fifo_ctrl_if #(.DATA_W(DATA_W)) m_bus ();

  ap3_fifo_ctrl #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .AE_LEVEL (AE),
    .AF_LEVEL (AF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .s_stream  (s_bus),
    .m_stream  (m_bus),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_wen   (ram_wen),
    .ram_raddr (ram_raddr),
    .ram_ren   (ram_ren),
    .ram_rdata (ram_rdata),
    .level     (level),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_wen) ram[ram_waddr] <= ram_wdata;
    if (ram_ren) ram_rdata <= ram[ram_raddr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_s_ready"}, 64'(s_bus.ready), 64'(0));
    chk({tag, "_m_valid"}, 64'(m_bus.valid), 64'(0));
    chk({tag, "_m_data"},  64'(m_bus.data),  64'(0));
    chk({tag, "_ram_wen"}, 64'(ram_wen),     64'(0));
    chk({tag, "_ram_ren"}, 64'(ram_ren),     64'(0));
    chk({tag, "_level"},   64'(level),       64'(0));
    chk({tag, "_flags"},   64'(flags),       64'(4'b0011));
  endtask

  // One clock cycle: inputs are already applied; check at the falling edge, then
  // advance the reference model across the rising edge.
  task automatic tick();
    int    lv;
    bit    rdy_known;
    bit    rdy_exp;
    bit    do_push;
    bit    do_pop;
    bit    mv_exp;
    word_t w;
    @(negedge clk);
    lv = q.size();
    chk("level",       64'(level),    64'(lv));
    chk("flag_empty",  64'(flags[0]), 64'(lv == 0));
    chk("flag_aempty", 64'(flags[1]), 64'(lv <= AE));
    chk("flag_afull",  64'(flags[2]), 64'(lv >= AF));
    if (lv < DEPTH)      chk("flag_full_lo", 64'(flags[3]), 64'(0));
    if (lv == DEPTH + 2) chk("flag_full_hi", 64'(flags[3]), 64'(1));

    rdy_known = 1'b1;
    rdy_exp   = 1'b0;
    if (!armed || flush)    rdy_exp = 1'b0;
    else if (lv < DEPTH)    rdy_exp = 1'b1;
    else if (lv == DEPTH+2) rdy_exp = 1'b0;
    else                    rdy_known = 1'b0;
    if (rdy_known) chk("s_ready", 64'(s_bus.ready), 64'(rdy_exp));
    else           rdy_exp = s_bus.ready;
    do_push = s_bus.valid && rdy_exp;
    chk("ram_wen", 64'(ram_wen), 64'(do_push));
    if (do_push) chk("ram_wdata", 64'(ram_wdata), 64'(s_bus.data));

    mv_exp = 1'b0;
    if (lv > 0) mv_exp = (cyc - q[0].t) >= 3;
    chk("m_valid", 64'(m_bus.valid), 64'(mv_exp));
    if (mv_exp) chk("m_data", 64'(m_bus.data), 64'(q[0].d));
    do_pop = mv_exp && m_bus.ready && !flush;
    if (flush || lv == 0) chk("ram_ren_idle", 64'(ram_ren), 64'(0));

    w.d = s_bus.data;
    w.t = cyc;
    @(posedge clk);
    #1;
    cyc++;
    armed = 1'b1;
    if (flush) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(w);
    end
  endtask

  initial begin
    s_bus.valid  = 1'b0;
    s_bus.data   = '0;
    m_bus.ready  = 1'b0;

    // Reset state, then the cycle right after release still refuses pushes.
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    rst_n = 1'b1;
    tick();

    // Single word: visible three cycles after the push, then popped.
    s_bus.valid = 1'b1;
    s_bus.data  = 32'hA5A5A5A5;
    tick();
    s_bus.valid = 1'b0;
    repeat (3) tick();
    chk("t1_head", 64'(m_bus.data), 64'(32'hA5A5A5A5));
    chk("t1_flags_one", 64'(flags), 64'(4'b0010));
    m_bus.ready = 1'b1;
    tick();
    m_bus.ready = 1'b0;
    tick();
    chk("t1_flags_back", 64'(flags), 64'(4'b0011));

    // Continuous streaming at one word per cycle.
    s_bus.valid = 1'b1;
    m_bus.ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      s_bus.data = $urandom;
      if (i == 500) chk("t2_level_steady", 64'(level), 64'(3));
      tick();
    end
    s_bus.valid = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    chk("t2_drained", 64'(q.size()), 64'(0));

    // Fill to the very top with the consumer stalled.
    m_bus.ready = 1'b0;
    s_bus.valid = 1'b1;
    for (int i = 0; i < 520; i++) begin
      s_bus.data = $urandom;
      tick();
    end
    s_bus.valid = 1'b0;
    tick();
    chk("t3_model_count", 64'(q.size()), 64'(DEPTH + 2));
    chk("t3_level", 64'(level), 64'(DEPTH + 2));
    chk("t3_full", 64'(flags[3]), 64'(1));
    chk("t3_s_ready", 64'(s_bus.ready), 64'(0));

    // Drain with a random consumer; the read pointer wraps on the way.
    for (int i = 0; i < 4000 && q.size() > 0; i++) begin
      m_bus.ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("t4_drained", 64'(q.size()), 64'(0));

    // Random traffic with occasional flushes.
    for (int i = 0; i < 2000; i++) begin
      s_bus.valid = 1'($urandom_range(0, 1));
      s_bus.data  = $urandom;
      m_bus.ready = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 63) == 0);
      tick();
    end
    flush       = 1'b0;
    s_bus.valid = 1'b0;
    m_bus.ready = 1'b1;
    for (int i = 0; i < 600 && q.size() > 0; i++) tick();
    chk("t4b_drained", 64'(q.size()), 64'(0));

    // Flush while a RAM read is in flight with ten words held.
    m_bus.ready = 1'b0;
    s_bus.valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      s_bus.data = 32'h5000_0000 + 32'(i);
      tick();
    end
    s_bus.valid = 1'b0;
    m_bus.ready = 1'b1;
    tick();
    chk("t5_level_before", 64'(level), 64'(10));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_level_after", 64'(level), 64'(0));
    chk("t5_m_valid_after", 64'(m_bus.valid), 64'(0));
    repeat (4) tick();

    // Short asynchronous reset pulse in the middle of a stream.
    s_bus.valid = 1'b1;
    m_bus.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_bus.data = $urandom;
      tick();
    end
    rst_n = 1'b0;
    #1;
    check_reset("t6");
    rst_n = 1'b1;
    q.delete();
    armed       = 1'b0;
    s_bus.valid = 1'b0;
    m_bus.ready = 1'b0;
    tick();
    s_bus.valid = 1'b1;
    s_bus.data  = 32'h1;
    tick();
    s_bus.valid = 1'b0;
    repeat (3) tick();
    chk("t6_data", 64'(m_bus.data), 64'(32'h1));
    m_bus.ready = 1'b1;
    tick();
    m_bus.ready = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
